// File: rtl/mem_access_ctrl_if.sv
// Processor-side and memory-side signal bundle for mem_access_ctrl.
// The slave modport belongs to the controller; the master modport belongs to whoever drives requests and models the memory.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;
    logic              mem_write_n;
    logic              mem_read_n;

    modport slave (
        input  req, we, addr, wdata, mem_out,
        output rdata, ack, busy, err, mem_addr, mem_in, mem_write_n, mem_read_n
    );

    modport master (
        output req, we, addr, wdata, mem_out,
        input  rdata, ack, busy, err, mem_addr, mem_in, mem_write_n, mem_read_n
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller with registered strobes and a one-cycle ack.
// Define MEM_ACCESS_VERIFY_EN to read back every write and flag a mismatch on err.
module mem_access_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             proc_rst,
    mem_access_ctrl_if.slave bus
);
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

`ifdef MEM_ACCESS_VERIFY_EN
    typedef enum logic [1:0] {IDLE, RD, WR, VRFY} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_nxt;
    logic [DATA_W-1:0] mem_in_q;
    logic [DATA_W-1:0] mem_in_nxt;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              ack_q;
    logic              ack_nxt;
    logic              busy_q;
    logic              rd_n_q;
    logic              rd_n_nxt;
    logic              wr_n_q;
    logic              wr_n_nxt;
    logic              free;
    logic              accept;
`ifdef MEM_ACCESS_VERIFY_EN
    logic              err_q;
    logic              err_nxt;
`endif

    // A completing access frees the controller on the same edge, so back-to-back requests lose no cycle.
    always_comb begin
        case (state)
            IDLE:    free = 1'b1;
            RD:      free = (cnt == 2'd0);
`ifdef MEM_ACCESS_VERIFY_EN
            WR:      free = 1'b0;
            VRFY:    free = (cnt == 2'd0);
`else
            WR:      free = 1'b1;
`endif
            default: free = 1'b1;
        endcase
    end

    assign accept = free && bus.req;

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            rdata_q    <= '0;
            mem_in_q   <= '0;
            mem_addr_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
`ifdef MEM_ACCESS_VERIFY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rdata_q    <= rdata_nxt;
            mem_in_q   <= mem_in_nxt;
            mem_addr_q <= mem_addr_nxt;
            ack_q      <= ack_nxt;
            busy_q     <= (state_nxt != IDLE);
            rd_n_q     <= rd_n_nxt;
            wr_n_q     <= wr_n_nxt;
`ifdef MEM_ACCESS_VERIFY_EN
            err_q      <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef MEM_ACCESS_VERIFY_EN
        if (state == WR) begin
            state_nxt = VRFY;
        end
`endif
        if (free) begin
            state_nxt = accept ? (bus.we ? WR : RD) : IDLE;
        end
    end

    // mem_in doubles as the latched write data, so the verify compare uses it directly.
    always_comb begin
        cnt_nxt      = cnt;
        rdata_nxt    = rdata_q;
        mem_addr_nxt = mem_addr_q;
        mem_in_nxt   = mem_in_q;
        ack_nxt      = 1'b0;
        rd_n_nxt     = 1'b1;
        wr_n_nxt     = 1'b1;
`ifdef MEM_ACCESS_VERIFY_EN
        err_nxt      = err_q;
`endif
        case (state)
            RD: begin
                if (cnt != 2'd0) begin
                    cnt_nxt  = cnt - 2'd1;
                    rd_n_nxt = 1'b0;
                end else begin
                    rdata_nxt = bus.mem_out;
                    ack_nxt   = 1'b1;
`ifdef MEM_ACCESS_VERIFY_EN
                    err_nxt   = 1'b0;
`endif
                end
            end
            WR: begin
`ifdef MEM_ACCESS_VERIFY_EN
                rd_n_nxt = 1'b0;
                cnt_nxt  = CNT_INIT;
`else
                ack_nxt  = 1'b1;
`endif
            end
`ifdef MEM_ACCESS_VERIFY_EN
            VRFY: begin
                if (cnt != 2'd0) begin
                    cnt_nxt  = cnt - 2'd1;
                    rd_n_nxt = 1'b0;
                end else begin
                    ack_nxt = 1'b1;
                    err_nxt = (bus.mem_out != mem_in_q);
                end
            end
`endif
            default: begin
            end
        endcase
        if (accept) begin
            mem_addr_nxt = bus.addr;
            if (bus.we) begin
                mem_in_nxt = bus.wdata;
                wr_n_nxt   = 1'b0;
            end else begin
                rd_n_nxt = 1'b0;
                cnt_nxt  = CNT_INIT;
            end
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.ack         = ack_q;
    assign bus.busy        = busy_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_in      = mem_in_q;
    assign bus.mem_read_n  = rd_n_q;
    assign bus.mem_write_n = wr_n_q;
`ifdef MEM_ACCESS_VERIFY_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a transaction-level model predicts each ack, a monitor checks it.
// Also builds with MEM_ACCESS_VERIFY_EN to exercise the write-verify path.
module tb_mem_access_ctrl;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_ACCESS_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WR_LAT     = VERIFY ? 1 + RD_LAT : 1;
    localparam int WR_RD_CYCS = VERIFY ? RD_LAT : 0;

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        bit                exp_err;
        int                exp_cyc;
    } txn_t;

    logic clk = 1'b0;
    logic proc_rst;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .proc_rst (proc_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    txn_t              sb[$];
    txn_t              mon_t;
    int                ack_log[$];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                free_cyc = 0;
    int                front_rd = 0;
    int                front_wr = 0;
    bit                cur_corrupt = 1'b0;
    logic [DATA_W-1:0] mem_arr [DEPTH];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responds on the falling edge; cur_corrupt flips the LSB of readback to provoke a verify error.
    always @(negedge clk) begin
        if (!bus.mem_write_n) mem_arr[bus.mem_addr] <= bus.mem_in;
        if (!bus.mem_read_n) bus.mem_out <= mem_arr[bus.mem_addr] ^ DATA_W'(cur_corrupt);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Completion is handled before strobe accounting, since a new access may start on the ack edge.
    always @(negedge clk) begin
        if (proc_rst) begin
            front_rd = 0;
            front_wr = 0;
        end else begin
            if (bus.ack) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_ack");
                end else begin
                    mon_t = sb.pop_front();
                    checkOutput("ack_cycle", 32'(cyc), 32'(mon_t.exp_cyc));
                    checkOutput("rdata", 32'(bus.rdata), 32'(mon_t.exp_rdata));
                    checkOutput("err", 32'(bus.err), 32'(mon_t.exp_err));
                    checkOutput("wr_strobe_cycles", 32'(front_wr), mon_t.is_wr ? 32'd1 : 32'd0);
                    checkOutput("rd_strobe_cycles", 32'(front_rd),
                                mon_t.is_wr ? 32'(WR_RD_CYCS) : 32'(RD_LAT));
                    ack_log.push_back(cyc);
                end
                front_rd = 0;
                front_wr = 0;
            end
            if (!bus.mem_read_n || !bus.mem_write_n) begin
                checkOutput("strobe_exclusive", 32'(!bus.mem_read_n && !bus.mem_write_n), 32'd0);
                if (sb.size() == 0) begin
                    failNow("spurious_strobe");
                end else begin
                    checkOutput("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
                    if (!bus.mem_write_n) begin
                        checkOutput("mem_in", 32'(bus.mem_in), 32'(sb[0].wdata));
                        front_wr++;
                    end
                    if (!bus.mem_read_n) front_rd++;
                end
            end
        end
    end

    // The controller is free at the edge where the previous access completes.
    task automatic applyStimulus(input bit w, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input bit corrupt);
        int   acc;
        txn_t t;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        acc = (free_cyc > cyc) ? free_cyc : cyc + 1;
        while (cyc < acc) begin
            @(posedge clk);
            #1;
        end
        t.is_wr   = w;
        t.addr    = a;
        t.wdata   = d;
        t.exp_cyc = acc + (w ? WR_LAT : RD_LAT);
        if (w) begin
            model_mem[a] = d;
            t.exp_rdata  = last_rd;
            t.exp_err    = VERIFY && corrupt;
        end else begin
            t.exp_rdata  = model_mem[a];
            t.exp_err    = 1'b0;
            last_rd      = model_mem[a];
        end
        free_cyc    = t.exp_cyc;
        cur_corrupt = VERIFY && w && corrupt;
        sb.push_back(t);
        checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic drain();
        bus.req = 1'b0;
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            failNow("drain_timeout");
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = DATA_W'($urandom);
            mem_arr[i]   = v;
            model_mem[i] = v;
        end
        mem_arr[3]   = 16'h2910;
        model_mem[3] = 16'h2910;

        // Reset with a request pending: it must be ignored.
        proc_rst  = 1'b1;
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = ADDR_W'(5);
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_ack", 32'(bus.ack), 32'd0);
        checkOutput("rst_read_n", 32'(bus.mem_read_n), 32'd1);
        checkOutput("rst_write_n", 32'(bus.mem_write_n), 32'd1);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_rdata", 32'(bus.rdata), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_mem_in", 32'(bus.mem_in), 32'd0);
        bus.req  = 1'b0;
        proc_rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, ADDR_W'(3), '0, 1'b0);
        drain();
        checkOutput("read_addr3", 32'(bus.rdata), 32'h2910);

        applyStimulus(1'b1, ADDR_W'(7), 16'hA5A5, 1'b0);
        applyStimulus(1'b0, ADDR_W'(7), '0, 1'b0);
        drain();
        checkOutput("read_back_addr7", 32'(bus.rdata), 32'hA5A5);

        ack_log.delete();
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, ADDR_W'($urandom), '0, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("burst_ack_count", 32'(ack_log.size()), 32'd4);
        for (int k = 1; k < ack_log.size(); k++)
            checkOutput("burst_ack_spacing", 32'(ack_log[k] - ack_log[k-1]), 32'(RD_LAT));
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);

        // Abort a read one cycle after it is accepted.
        applyStimulus(1'b0, ADDR_W'(9), '0, 1'b0);
        bus.req  = 1'b0;
        proc_rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_read_n", 32'(bus.mem_read_n), 32'd1);
        checkOutput("abort_write_n", 32'(bus.mem_write_n), 32'd1);
        checkOutput("abort_ack", 32'(bus.ack), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_rdata", 32'(bus.rdata), 32'd0);
        sb.delete();
        last_rd  = '0;
        free_cyc = 0;
        proc_rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_rdata_held", 32'(bus.rdata), 32'd0);

        applyStimulus(1'b1, ADDR_W'(20), 16'h1234, 1'b1);
        drain();
        applyStimulus(1'b1, ADDR_W'(20), 16'h1234, 1'b0);
        drain();

        for (int n = 0; n < 80; n++) begin
            int gap;
            applyStimulus(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), ($urandom % 4) == 0);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                bus.req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        drain();
        checkOutput("final_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
